rom_burst_reader: RTL



---
 rtl/rom_burst_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst sequencer for a pipelined ROM with skid FIFO output
// Optional running XOR checksum of popped bytes: define ROM_RD_CSUM_EN.
module rom_burst_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef ROM_RD_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum,
  output logic              csum_valid
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, remain;
  logic [LAT-1:0]    vpipe, lpipe;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [SW-1:0]     pipe_cnt;
  logic              accept, issue, push, push_last, pop, credit_ok, last_issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rom_addr   = addr_cnt;
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (fifo_cnt != '0);
  assign out_data   = mem_data[rd_ptr];
  assign out_last   = out_valid & mem_last[rd_ptr];
  assign pop        = out_valid & out_ready;
  assign push       = vpipe[LAT-1];
  assign push_last  = lpipe[LAT-1];
  assign last_issue = issue && (remain == '0);

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LAT; i++) pipe_cnt = pipe_cnt + SW'(vpipe[i]);
  end

  // Credit check: every token already in the ROM pipe or FIFO, plus the new one,
  // must have a FIFO slot waiting for it since the pipe cannot stall.
  assign credit_ok = (pipe_cnt + SW'(fifo_cnt) + SW'(1)) <= (SW'(FIFO_DEPTH) + SW'(pop));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remain == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
      remain   <= '0;
    end else if (accept) begin
      addr_cnt <= req_addr;
      remain   <= req_len;
    end else if (issue && (remain != '0)) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
      remain   <= remain - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | LAT'(issue);
      lpipe <= (lpipe << 1) | LAT'(last_issue);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
      mem_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= rom_dout;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef ROM_RD_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      if (accept)   csum <= '0;
      else if (pop) csum <= csum ^ out_data;
      csum_valid <= pop & out_last;
    end
  end
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))));

endmodule
